// File: rtl/dspl_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver: one digit per scan slot,
// with hex decode, decimal point, per-digit enable, blink and PWM brightness.
module dspl_scan_mux #(
    parameter int  N_DIGITS  = 8,
    parameter int  SCAN_DIV  = 100000,
    parameter int  BLINK_DIV = 25000000,
    localparam int IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic [3:0]            bright,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            dec_ddp,
    output logic [IDX_W-1:0]      scan_idx
);

    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);

    logic [SLOT_W-1:0]   slot_cnt_q,  slot_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [3:0]          pwm_cnt_q,   pwm_cnt_d;
    logic [IDX_W-1:0]    scan_idx_q,  scan_idx_d;
    logic [5:0]          snap_q,      snap_d;
    logic [N_DIGITS-1:0] an_q,        an_d;
    logic [7:0]          dec_q,       dec_d;

    logic                slot_wrap;
    logic                blink_wrap;
    logic                lit;
    logic [5:0]          digit_fields [N_DIGITS];

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            digit_fields[i] = digits[6*i +: 6];
        end
    end

    // The snapshot is taken only at the slot wrap, so mid-slot input changes never reach the pins.
    always_comb begin
        slot_wrap   = (slot_cnt_q == SLOT_LAST);
        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        scan_idx_d  = scan_idx_q;
        snap_d      = snap_q;
        if (slot_wrap) begin
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
            snap_d     = digit_fields[scan_idx_d];
        end

        blink_wrap    = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blink_wrap;
        pwm_cnt_d     = pwm_cnt_q + 4'd1;

        lit   = snap_q[5] && !(blink_phase_q && blink_mask[scan_idx_q]) && (pwm_cnt_q <= bright);
        an_d  = '1;
        dec_d = 8'hFF;
        if (lit) begin
            an_d  = ~(N_DIGITS'(1) << scan_idx_q);
            dec_d = {seg7(snap_q[4:1]), ~snap_q[0]};
        end
    end

    // Outputs are registered so the pins change one clock after the state that drives them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pwm_cnt_q     <= 4'd0;
            scan_idx_q    <= '0;
            snap_q        <= 6'd0;
            an_q          <= '1;
            dec_q         <= 8'hFF;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pwm_cnt_q     <= pwm_cnt_d;
            scan_idx_q    <= scan_idx_d;
            snap_q        <= snap_d;
            an_q          <= an_d;
            dec_q         <= dec_d;
        end
    end

    assign an       = an_q;
    assign dec_ddp  = dec_q;
    assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_dspl_scan_mux.sv
// Scoreboard bench for dspl_scan_mux: stimulus queues expected pin values tagged
// with the clock edge (counted from reset release) at which they must appear.
module tb_dspl_scan_mux;

    localparam int N_DIGITS  = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] digits;
    logic [3:0]  blink_mask;
    logic [3:0]  bright;
    logic [3:0]  an;
    logic [7:0]  dec_ddp;
    logic [1:0]  scan_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         phase;
        int         edge_no;
        logic [3:0] an;
        logic [7:0] dec;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q [$];

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Pin patterns for the base digit set {1,0,0},{1,1,0},{1,2,1},{1,3,0} on digits 0..3
    logic [7:0] base_dec [4] = '{8'h03, 8'h9F, 8'h24, 8'h0D};

    dspl_scan_mux #(
        .N_DIGITS  (N_DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .blink_mask (blink_mask),
        .bright     (bright),
        .an         (an),
        .dec_ddp    (dec_ddp),
        .scan_idx   (scan_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc = 0;
        else      cyc = cyc + 1;
    end

    // Monitor: compares every queued expectation whose edge has arrived, plus the one-hot anode rule.
    always @(negedge clk) begin
        exp_t r;
        total++;
        if ($countones(~an) > 1) begin
            bad++;
            $display("[TB] FAIL onehot e%0d: an=%b, want at most one low bit", cyc, an);
        end
        while (exp_q.size() > 0 && exp_q[0].edge_no <= cyc) begin
            r = exp_q.pop_front();
            total++;
            if (r.edge_no < cyc) begin
                bad++;
                $display("[TB] FAIL ph%0d e%0d: check missed, now at e%0d", r.phase, r.edge_no, cyc);
            end else if (an !== r.an || dec_ddp !== r.dec || scan_idx !== r.idx) begin
                bad++;
                $display("[TB] FAIL ph%0d e%0d: got an=%b dec=%h idx=%0d, want an=%b dec=%h idx=%0d",
                         r.phase, r.edge_no, an, dec_ddp, scan_idx, r.an, r.dec, r.idx);
            end
        end
    end

    task automatic push_exp(input int ph, input int e, input logic [3:0] a,
                            input logic [7:0] d, input logic [1:0] i);
        exp_t r;
        r.phase   = ph;
        r.edge_no = e;
        r.an      = a;
        r.dec     = d;
        r.idx     = i;
        exp_q.push_back(r);
    endtask

    task automatic wait_edge(input int n);
        int guard;
        guard = 0;
        while (cyc != n) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                $display("[TB] FAIL wait_edge: reached e%0d, want e%0d", cyc, n);
                $fatal(1, "[TB] stimulus lost sync");
            end
        end
    endtask

    task automatic push_pwm(input int lo, input int hi, input int br);
        for (int e = lo; e <= hi; e++) begin
            int  d;
            bit  on;
            d  = ((e - 1) / 4) % 4;
            on = (((e - 1) % 16) <= br);
            push_exp(4, e, on ? ~4'(1 << d) : 4'hF, on ? base_dec[d] : 8'hFF, 2'((e / 4) % 4));
        end
    endtask

    initial begin
        int drain;
        digits     = {6'h26, 6'h25, 6'h22, 6'h20};
        bright     = 4'd15;
        blink_mask = 4'b0000;

        // Reset state, then the first pass through all four slots
        push_exp(1, 0,  4'hF,    8'hFF, 2'd0);
        push_exp(1, 2,  4'hF,    8'hFF, 2'd0);
        push_exp(1, 4,  4'hF,    8'hFF, 2'd1);
        push_exp(1, 6,  4'b1101, 8'h9F, 2'd1);
        push_exp(1, 8,  4'b1101, 8'h9F, 2'd2);
        push_exp(1, 10, 4'b1011, 8'h24, 2'd2);
        push_exp(1, 12, 4'b1011, 8'h24, 2'd3);
        push_exp(1, 14, 4'b0111, 8'h0D, 2'd3);
        push_exp(1, 16, 4'b0111, 8'h0D, 2'd0);
        push_exp(1, 18, 4'b1110, 8'h03, 2'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Hex sweep: round r shows value 4r+i on digit i, dp = value bit 0
        for (int r = 0; r < 4; r++) begin
            int e0;
            e0 = 16 + 16 * r;
            wait_edge(e0);
            for (int i = 0; i < 4; i++) begin
                logic [3:0] v;
                v = 4'(4 * r + i);
                digits[6*i +: 6] = {1'b1, v, v[0]};
            end
            for (int k = 1; k <= 4; k++) begin
                int         i;
                logic [3:0] v;
                i = k % 4;
                v = 4'(4 * r + i);
                push_exp(2, e0 + 4 * k + 2, ~4'(1 << i), {seg_tab[v], ~v[0]}, 2'(i));
            end
        end

        // Disabled digit 1 stays dark; digit 0 ignores a mid-slot change
        wait_edge(80);
        digits = {6'h3F, 6'h3C, 6'h0A, 6'h2F};
        push_exp(3, 86,  4'hF,    8'hFF, 2'd1);
        push_exp(3, 88,  4'hF,    8'hFF, 2'd2);
        push_exp(3, 90,  4'b1011, 8'h61, 2'd2);
        push_exp(3, 94,  4'b0111, 8'h70, 2'd3);
        push_exp(3, 98,  4'b1110, 8'h1E, 2'd0);
        push_exp(3, 99,  4'b1110, 8'h1E, 2'd0);
        push_exp(3, 100, 4'b1110, 8'h1E, 2'd1);
        push_exp(3, 114, 4'b1110, 8'h01, 2'd0);
        wait_edge(97);
        digits[5:0] = 6'h30;
        wait_edge(112);
        digits = {6'h26, 6'h25, 6'h22, 6'h20};

        // Brightness: 4 of 16 clocks lit at bright=3, 1 of 16 at bright=0
        wait_edge(128);
        bright = 4'd3;
        push_pwm(129, 160, 3);
        wait_edge(160);
        bright = 4'd0;
        push_pwm(161, 192, 0);

        // Blink on digit 2: visible while phase=0, blank while phase=1, others unaffected
        wait_edge(192);
        bright     = 4'd15;
        blink_mask = 4'b0100;
        push_exp(5, 202, 4'b1011, 8'h24, 2'd2);
        push_exp(5, 218, 4'b1011, 8'h24, 2'd2);
        push_exp(5, 230, 4'b1101, 8'h9F, 2'd1);
        push_exp(5, 234, 4'hF,    8'hFF, 2'd2);
        push_exp(5, 238, 4'b0111, 8'h0D, 2'd3);
        push_exp(5, 242, 4'b1110, 8'h03, 2'd0);
        push_exp(5, 250, 4'hF,    8'hFF, 2'd2);
        push_exp(5, 266, 4'b1011, 8'h24, 2'd2);
        push_exp(6, 282, 4'b1011, 8'h24, 2'd2);

        // Asynchronous reset in the middle of slot 2
        wait_edge(282);
        #2 rst = 1'b0;
        #1;
        total++;
        if (an !== 4'hF || dec_ddp !== 8'hFF || scan_idx !== 2'd0) begin
            bad++;
            $display("[TB] FAIL async_reset: got an=%b dec=%h idx=%0d, want an=1111 dec=ff idx=0",
                     an, dec_ddp, scan_idx);
        end
        digits = {6'h06, 6'h05, 6'h02, 6'h2B};
        push_exp(6, 0,  4'hF,    8'hFF, 2'd0);
        push_exp(6, 2,  4'hF,    8'hFF, 2'd0);
        push_exp(6, 4,  4'hF,    8'hFF, 2'd1);
        push_exp(6, 6,  4'hF,    8'hFF, 2'd1);
        push_exp(6, 10, 4'hF,    8'hFF, 2'd2);
        push_exp(6, 14, 4'hF,    8'hFF, 2'd3);
        push_exp(6, 18, 4'b1110, 8'h48, 2'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        drain = 0;
        while (exp_q.size() > 0 && drain < 100) begin
            @(negedge clk);
            drain++;
        end
        #1;
        while (exp_q.size() > 0) begin
            exp_t r;
            r = exp_q.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL ph%0d e%0d: never compared, got to e%0d", r.phase, r.edge_no, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
